// File: rtl/coreaxi4dmacontroller_int_event_queue.sv
// Interrupt event queue behind the DMA controller.
// Completion/error events are queued in a small FIFO. One level interrupt is
// raised per queued event, and firmware retires the head event with intClr.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a queued event; drops head events that are now masked
// ASSERT | INTERRUPT high; waiting for firmware to pulse intClr
// POP    | retire head entry; INTERRUPT low (gap before next event)
module coreaxi4dmacontroller_int_event_queue #(
    parameter int ID_WIDTH   = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                CLOCK,
    input  logic                RESETN,
    input  logic                valid,
    output logic                ready,
    input  logic                opDone,
    input  logic                wrError,
    input  logic                rdError,
    input  logic                invalidDscrptr,
    input  logic                strDscrptr,
    input  logic [ID_WIDTH-1:0] intDscrptrNum,
    input  logic [31:0]         extDscrptrAddr,
    input  logic [3:0]          intMask,
    input  logic                intClr,
    output logic [7:0]          intStatus,
    output logic [ID_WIDTH-1:0] intDscrptrNumOut,
    output logic [31:0]         intExtAddr,
    output logic [PTR_W:0]      intPending,
    output logic                INTERRUPT
);

    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_POP    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]          mem_flags [FIFO_DEPTH];
    logic                mem_str   [FIFO_DEPTH];
    logic [ID_WIDTH-1:0] mem_num   [FIFO_DEPTH];
    logic [31:0]         mem_addr  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [PTR_W:0]   count;
    logic [3:0]       evt_flags;
    logic             store;
    logic             pop;

    assign evt_flags  = {invalidDscrptr, rdError, wrError, opDone};
    assign ready      = (count != COUNT_FULL);
    // Fully masked events complete the handshake but never occupy a slot.
    assign store      = valid & ready & (|(evt_flags & intMask));
    assign pop        = (state == ST_POP);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    assign intPending = count;

    // Event storage, written at the write pointer on every stored push.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_flags[i] <= '0;
                mem_str[i]   <= 1'b0;
                mem_num[i]   <= '0;
                mem_addr[i]  <= '0;
            end
        end else if (store) begin
            mem_flags[wr_ptr] <= evt_flags;
            mem_str[wr_ptr]   <= strDscrptr;
            mem_num[wr_ptr]   <= intDscrptrNum;
            mem_addr[wr_ptr]  <= extDscrptrAddr;
        end
    end

    // Pointers and occupancy; push and pop in the same cycle leave count unchanged.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({store, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered head outputs; on a pop they move straight to the next entry
    // (or to zero) so they never show a retired event while the queue is empty.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            intStatus        <= '0;
            intDscrptrNumOut <= '0;
            intExtAddr       <= '0;
        end else if (pop) begin
            if (count > COUNT_ONE) begin
                intStatus        <= {3'b000, mem_str[rd_ptr_inc], mem_flags[rd_ptr_inc]};
                intDscrptrNumOut <= mem_num[rd_ptr_inc];
                intExtAddr       <= mem_addr[rd_ptr_inc];
            end else begin
                intStatus        <= '0;
                intDscrptrNumOut <= '0;
                intExtAddr       <= '0;
            end
        end else if (count != '0) begin
            intStatus        <= {3'b000, mem_str[rd_ptr], mem_flags[rd_ptr]};
            intDscrptrNumOut <= mem_num[rd_ptr];
            intExtAddr       <= mem_addr[rd_ptr];
        end else begin
            intStatus        <= '0;
            intDscrptrNumOut <= '0;
            intExtAddr       <= '0;
        end
    end

    // State register and registered interrupt (high exactly while in ASSERT).
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= ST_IDLE;
            INTERRUPT <= 1'b0;
        end else begin
            state     <= state_nxt;
            INTERRUPT <= (state_nxt == ST_ASSERT);
        end
    end

    // Next-state logic; IDLE looks at storage directly because the registered
    // head copy lags the count by one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    if (|(mem_flags[rd_ptr] & intMask)) begin
                        state_nxt = ST_ASSERT;
                    end else begin
                        state_nxt = ST_POP;
                    end
                end
            end
            ST_ASSERT: begin
                if (intClr) begin
                    state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
